seq_mult16: RTL and testbench

- Sequential 16x16 unsigned shift-and-add multiplier. Produces a 32-bit product.
- Sits directly around the team's 17-bit ripple adder (adder17), which it instantiates once:
  - drives the adder's A/B operands each iteration;
  - consumes its 18-bit sum S to update the accumulator.
- Valid/ready handshakes on both input and output, so it drops into the datapath between operand registers and the result consumer.

---
 rtl/adder17.sv | 21 ++
 rtl/seq_mult16.sv | 108 ++++++++++
 tb/tb_seq_mult16.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/adder17.sv
// 17-bit ripple-carry adder with an 18-bit sum (bit 17 is the carry-out).
module adder17 (
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [17:0] s
);

  logic carry;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < 17; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    s[17] = carry;
  end

endmodule

// File: rtl/seq_mult16.sv
// Sequential 16x16 unsigned shift-and-add multiplier with valid/ready handshakes.
// One add per cycle through adder17; a full operation always takes 16 iterations.
module seq_mult16 #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [4:0] LastCount = 5'(ITER - 1);

  state_e      state_q, state_d;
  logic [15:0] mcand_q;
  logic [16:0] acc_hi_q;
  logic [15:0] acc_lo_q;
  logic [4:0]  count_q;
  logic [31:0] product_q;

  logic [16:0] add_a;
  logic [16:0] add_b;
  logic [17:0] add_s;

  // Partial-product add: accumulate the multiplicand when the current multiplier bit is set.
  // acc_hi stays below 2^16 before each add, so add_s[17] is always 0 and is simply shifted in.
  always_comb begin
    add_a = acc_hi_q;
    add_b = acc_lo_q[0] ? {1'b0, mcand_q} : 17'd0;
  end

  adder17 u_adder (
    .a(add_a),
    .b(add_b),
    .s(add_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (count_q == LastCount) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: load operands on accept, shift-add while running, capture product on last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q  <= a;
            acc_hi_q <= '0;
            acc_lo_q <= b;
            count_q  <= '0;
          end
        end
        StRun: begin
          acc_hi_q <= add_s[17:1];
          acc_lo_q <= {add_s[0], acc_lo_q[15:1]};
          count_q  <= count_q + 5'd1;
          if (count_q == LastCount) begin
            product_q <= {add_s[16:1], add_s[0], acc_lo_q[15:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed corner cases plus randomized operations
// scored against a plain a*b reference queue.
module tb_seq_mult16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  logic [31:0] exp_q[$];

  seq_mult16 #(.ITER(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one operation starting at a negedge in IDLE; ends at the negedge after the return
  // to IDLE. Junk operands and in_valid pulses are driven while busy and must be ignored.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input int stall);
    logic [31:0] exp;
    logic [31:0] held;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    check_eq("out_valid_idle", 32'(out_valid), 32'd0);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    exp_q.push_back(32'(op_a) * 32'(op_b));
    @(negedge clk);
    // 16 RUN cycles: busy, no result, adder carry-out never set.
    for (int i = 0; i < 16; i++) begin
      check_eq("in_ready_run", 32'(in_ready), 32'd0);
      check_eq("out_valid_run", 32'(out_valid), 32'd0);
      check_eq("adder_s17", 32'(dut.add_s[17]), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(negedge clk);
    end
    check_eq("latency_out_valid", 32'(out_valid), 32'd1);
    exp  = exp_q.pop_front();
    held = exp;
    // Backpressure: product and handshakes frozen.
    for (int i = 0; i < stall; i++) begin
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_product", product, held);
      in_valid = 1'($urandom_range(0, 1));
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(negedge clk);
    end
    check_eq("product", product, exp);
    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("out_valid_after", 32'(out_valid), 32'd0);
    check_eq("in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd3, 16'd5, 0);
    check_eq("basic_value", product, 32'h0000_000F);
    run_op(16'hFFFF, 16'hFFFF, 0);
    check_eq("max_value", product, 32'hFFFE_0001);
    run_op(16'h1234, 16'h0000, 1);
    run_op(16'h1234, 16'h0001, 2);
    run_op(16'h8000, 16'h8000, 0);
    check_eq("msb_value", product, 32'h4000_0000);
    run_op(16'h00FF, 16'h0100, 10);
    check_eq("bp_value", product, 32'h0000_FF00);

    // Asynchronous reset in the middle of RUN discards the operation.
    a        = 16'hABCD;
    b        = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op(16'd7, 16'd9, 0);
    check_eq("post_rst_value", product, 32'h0000_003F);

    // Randomized back-to-back operations with random stalls.
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 50 == 0) ra = 16'hFFFF;
      if (n % 70 == 0) rb = 16'h0000;
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
